// File: rtl/hit_logger_if.sv
// Output stream of hit_logger: a show-ahead timestamp FIFO head.
// Handshake: a beat transfers on a rising clk edge with out_valid & out_ready; out_ts is held while out_valid & !out_ready.
interface hit_logger_if #(
  parameter int TSW = 16
);
  logic           out_valid;
  logic           out_ready;
  logic [TSW-1:0] out_ts;

  modport master (output out_valid, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/hit_logger.sv
// Timestamps gated hit pulses from a free-running counter into a small FIFO with sticky overflow.
// Optional saturating drop counter is enabled by defining HIT_LOGGER_DROPCNT_EN.
module hit_logger #(
  parameter int TSW     = 16,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit,
  input  logic                       clr,
  hit_logger_if.master               out_if,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [TSW-1:0] ts_q, ts_d;
  logic [HW-1:0]  hoc_q, hoc_d;
  logic [TSW-1:0] mem_q [DEPTH];
  logic [TSW-1:0] mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic           gated, full, pop, push, drop;

  // A full FIFO still takes a hit when the head leaves in the same cycle.
  always_comb begin
    gated = hit & ((HOLDOFF == 0) || (hoc_q == '0));
    full  = (level_q == LW'(DEPTH));
    pop   = (level_q != '0) & out_if.out_ready;
    push  = gated & (~full | pop);
    drop  = gated & full & ~pop;
  end

  always_comb begin
    ts_d    = ts_q + TSW'(1);
    hoc_d   = hoc_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d   = clr ? 1'b0 : ovf_q;

    // Dropped hits reload the holdoff too; ignored hits never do.
    if (HOLDOFF == 0)       hoc_d = '0;
    else if (gated)         hoc_d = HW'(HOLDOFF);
    else if (hoc_q != '0)   hoc_d = hoc_q - HW'(1);

    if (push) begin
      mem_d[wptr_q] = ts_q;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (drop) ovf_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      hoc_q   <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      hoc_q   <= hoc_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_valid = (level_q != '0);
  assign out_if.out_ts    = mem_q[rptr_q];
  assign level            = level_q;
  assign ovf              = ovf_q;

`ifdef HIT_LOGGER_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Clear takes effect before a drop in the same cycle, so that drop still counts.
  always_comb begin
    drop_cnt_d = clr ? 8'd0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hit_logger.sv
// Bench for hit_logger: three instances (default, HOLDOFF=3, TSW=4) driven from one sequenced initial block.
module tb_hit_logger;

`ifdef HIT_LOGGER_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic hit0, clr0, hit1, clr1, hit2, clr2;
  logic [2:0] level0, level1, level2;
  logic ovf0, ovf1, ovf2;
  logic [7:0] drop0, drop1, drop2;

  hit_logger_if #(.TSW(16)) if0 ();
  hit_logger_if #(.TSW(16)) if1 ();
  hit_logger_if #(.TSW(4))  if2 ();

  hit_logger #(.TSW(16), .DEPTH(4), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hit(hit0), .clr(clr0), .out_if(if0),
    .level(level0), .ovf(ovf0), .drop_cnt(drop0)
  );
  hit_logger #(.TSW(16), .DEPTH(4), .HOLDOFF(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .hit(hit1), .clr(clr1), .out_if(if1),
    .level(level1), .ovf(ovf1), .drop_cnt(drop1)
  );
  hit_logger #(.TSW(4), .DEPTH(4), .HOLDOFF(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .hit(hit2), .clr(clr2), .out_if(if2),
    .level(level2), .ovf(ovf2), .drop_cnt(drop2)
  );

  // clock/reset block; tb_ts models the free-running stamp counter
  logic [15:0] tb_ts;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 16'd0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;
  int exp_drops;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hit0 = 0; clr0 = 0; hit1 = 0; clr1 = 0; hit2 = 0; clr2 = 0;
    if0.out_ready = 0; if1.out_ready = 0; if2.out_ready = 0;
    exp_q.delete();
    exp_drops = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hit0 = 0; clr0 = 0; hit1 = 0; clr1 = 0; hit2 = 0; clr2 = 0;
    if0.out_ready = 0; if1.out_ready = 0; if2.out_ready = 0;
    #1;
    n_checks++; if (if0.out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", if0.out_valid); else n_pass++;
    n_checks++; if (if0.out_ts !== 16'd0) $display("FAIL reset_ts got %0d exp 0", if0.out_ts); else n_pass++;
    n_checks++; if (level0 !== 3'd0) $display("FAIL reset_level got %0d exp 0", level0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", ovf0); else n_pass++;
    n_checks++; if (drop0 !== 8'd0) $display("FAIL reset_drop got %0d exp 0", drop0); else n_pass++;
    n_checks++; if (if1.out_valid !== 1'b0 || if2.out_valid !== 1'b0) $display("FAIL reset_valid_other got %0b/%0b exp 0/0", if1.out_valid, if2.out_valid); else n_pass++;
    #20;
  endtask

  task automatic test_single();
    do_reset();
    while (tb_ts != 16'd10) @(negedge clk);
    hit0 = 1;
    @(negedge clk);
    hit0 = 0;
    n_checks++; if (if0.out_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", if0.out_valid); else n_pass++;
    n_checks++; if (if0.out_ts !== 16'd10) $display("FAIL single_ts got %0d exp 10", if0.out_ts); else n_pass++;
    n_checks++; if (level0 !== 3'd1) $display("FAIL single_level got %0d exp 1", level0); else n_pass++;
    @(negedge clk);
    n_checks++; if (if0.out_ts !== 16'd10) $display("FAIL single_hold_ts got %0d exp 10", if0.out_ts); else n_pass++;
    if0.out_ready = 1;
    @(negedge clk);
    if0.out_ready = 0;
    n_checks++; if (if0.out_valid !== 1'b0) $display("FAIL single_drained_valid got %0b exp 0", if0.out_valid); else n_pass++;
    n_checks++; if (level0 !== 3'd0) $display("FAIL single_drained_level got %0d exp 0", level0); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    while (tb_ts != 16'd5) @(negedge clk);
    repeat (6) begin
      hit0 = 1;
      if (exp_q.size() < 4) exp_q.push_back(tb_ts);
      else exp_drops++;
      @(negedge clk);
    end
    hit0 = 0;
    n_checks++; if (level0 !== 3'd4) $display("FAIL ovf_level got %0d exp 4", level0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", ovf0); else n_pass++;
    n_checks++; if (drop0 !== (DROP_EN ? 8'(exp_drops) : 8'd0)) $display("FAIL ovf_drop got %0d exp %0d", drop0, DROP_EN ? exp_drops : 0); else n_pass++;
    if0.out_ready = 1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      exp = exp_q.pop_front();
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_ts !== exp) $display("FAIL ovf_drain valid %0b ts got %0d exp %0d", if0.out_valid, if0.out_ts, exp); else n_pass++;
      @(negedge clk);
    end
    if0.out_ready = 0;
    n_checks++; if (if0.out_valid !== 1'b0 || level0 !== 3'd0) $display("FAIL ovf_empty valid %0b level got %0d exp 0", if0.out_valid, level0); else n_pass++;
  endtask

  task automatic test_full_passthru();
    do_reset();
    repeat (4) begin
      hit0 = 1;
      exp_q.push_back(tb_ts);
      @(negedge clk);
    end
    n_checks++; if (level0 !== 3'd4) $display("FAIL pass_full_level got %0d exp 4", level0); else n_pass++;
    if0.out_ready = 1;
    exp = exp_q.pop_front();
    n_checks++; if (if0.out_ts !== exp) $display("FAIL pass_head_ts got %0d exp %0d", if0.out_ts, exp); else n_pass++;
    exp_q.push_back(tb_ts);
    @(negedge clk);
    hit0 = 0;
    if0.out_ready = 0;
    n_checks++; if (level0 !== 3'd4) $display("FAIL pass_level got %0d exp 4", level0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b0) $display("FAIL pass_ovf got %0b exp 0", ovf0); else n_pass++;
    if0.out_ready = 1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      exp = exp_q.pop_front();
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_ts !== exp) $display("FAIL pass_drain valid %0b ts got %0d exp %0d", if0.out_valid, if0.out_ts, exp); else n_pass++;
      @(negedge clk);
    end
    if0.out_ready = 0;
  endtask

  task automatic test_holdoff();
    int hoc;
    hoc = 0;
    do_reset();
    while (tb_ts != 16'd20) @(negedge clk);
    repeat (8) begin
      hit1 = 1;
      if (hoc == 0) begin
        exp_q.push_back(tb_ts);
        hoc = 3;
      end else begin
        hoc--;
      end
      @(negedge clk);
    end
    hit1 = 0;
    n_checks++; if (level1 !== 3'(exp_q.size())) $display("FAIL hold_level got %0d exp %0d", level1, exp_q.size()); else n_pass++;
    n_checks++; if (ovf1 !== 1'b0 || drop1 !== 8'd0) $display("FAIL hold_ovf_drop got %0b/%0d exp 0/0", ovf1, drop1); else n_pass++;
    if1.out_ready = 1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      exp = exp_q.pop_front();
      n_checks++; if (if1.out_valid !== 1'b1 || if1.out_ts !== exp) $display("FAIL hold_drain valid %0b ts got %0d exp %0d", if1.out_valid, if1.out_ts, exp); else n_pass++;
      @(negedge clk);
    end
    if1.out_ready = 0;
    n_checks++; if (if1.out_valid !== 1'b0) $display("FAIL hold_empty got %0b exp 0", if1.out_valid); else n_pass++;
  endtask

  task automatic test_clr();
    do_reset();
    repeat (4) begin
      hit0 = 1;
      exp_q.push_back(tb_ts);
      @(negedge clk);
    end
    repeat (2) begin
      hit0 = 1;
      exp_drops++;
      @(negedge clk);
    end
    hit0 = 0;
    n_checks++; if (ovf0 !== 1'b1) $display("FAIL clr_pre_ovf got %0b exp 1", ovf0); else n_pass++;
    n_checks++; if (drop0 !== (DROP_EN ? 8'(exp_drops) : 8'd0)) $display("FAIL clr_pre_drop got %0d exp %0d", drop0, DROP_EN ? exp_drops : 0); else n_pass++;
    clr0 = 1;
    hit0 = 1;
    exp_drops = 1;
    @(negedge clk);
    clr0 = 0;
    hit0 = 0;
    n_checks++; if (ovf0 !== 1'b1) $display("FAIL clr_drop_ovf got %0b exp 1", ovf0); else n_pass++;
    n_checks++; if (drop0 !== (DROP_EN ? 8'(exp_drops) : 8'd0)) $display("FAIL clr_drop_cnt got %0d exp %0d", drop0, DROP_EN ? exp_drops : 0); else n_pass++;
    clr0 = 1;
    @(negedge clk);
    clr0 = 0;
    n_checks++; if (ovf0 !== 1'b0 || drop0 !== 8'd0) $display("FAIL clr_only got %0b/%0d exp 0/0", ovf0, drop0); else n_pass++;
    n_checks++; if (level0 !== 3'd4) $display("FAIL clr_level got %0d exp 4", level0); else n_pass++;
    if0.out_ready = 1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      exp = exp_q.pop_front();
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_ts !== exp) $display("FAIL clr_drain valid %0b ts got %0d exp %0d", if0.out_valid, if0.out_ts, exp); else n_pass++;
      @(negedge clk);
    end
    if0.out_ready = 0;
  endtask

  task automatic test_wrap_async_reset();
    logic [3:0] first_stamp;
    do_reset();
    while (tb_ts != 16'd17) @(negedge clk);
    first_stamp = tb_ts[3:0];
    repeat (3) begin
      hit2 = 1;
      @(negedge clk);
    end
    hit2 = 0;
    n_checks++; if (if2.out_ts !== first_stamp) $display("FAIL wrap_ts got %0d exp %0d", if2.out_ts, first_stamp); else n_pass++;
    n_checks++; if (level2 !== 3'd3) $display("FAIL wrap_level got %0d exp 3", level2); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (if2.out_valid !== 1'b0) $display("FAIL async_valid got %0b exp 0", if2.out_valid); else n_pass++;
    n_checks++; if (level2 !== 3'd0) $display("FAIL async_level got %0d exp 0", level2); else n_pass++;
    n_checks++; if (if2.out_ts !== 4'd0) $display("FAIL async_ts got %0d exp 0", if2.out_ts); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_passthru();
    test_holdoff();
    test_clr();
    test_wrap_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
